// File: rtl/sipo_stream.sv
// Serial-to-parallel word assembler with valid/ready holding register and sticky overrun.
// Define SIPO_STREAM_PARITY_EN to add a trailing even-parity bit per frame and r_parity_err_out.
module sipo_stream #(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(SIZE + 2)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_in,
  input  logic             en_in,
  input  logic             clr_in,
  input  logic             ready_in,
  output logic [SIZE-1:0]  r_data_out,
  output logic             r_valid_out,
  output logic             r_overrun_out,
`ifdef SIPO_STREAM_PARITY_EN
  output logic             r_parity_err_out,
`endif
  output logic [CNT_W-1:0] r_bitcnt_out
);

`ifdef SIPO_STREAM_PARITY_EN
  localparam int LAST = SIZE;
`else
  localparam int LAST = SIZE - 1;
`endif

  logic [SIZE-1:0] sr;
  logic [SIZE-1:0] sr_shift;
  logic [SIZE-1:0] word_next;
  logic            strobe;
  logic            complete;
  logic            shift_data;
  logic            consume;
  logic            load;
  logic            overrun_set;

  always_comb begin
    sr_shift = sr;
    if (MSB_FIRST) sr_shift = {sr[SIZE-2:0], data_in};
    else           sr_shift = {data_in, sr[SIZE-1:1]};
  end

  assign strobe   = en_in && !clr_in;
  assign complete = strobe && (r_bitcnt_out == CNT_W'(LAST));

`ifdef SIPO_STREAM_PARITY_EN
  // The final strobe of a frame carries parity, so the data word is already in sr.
  assign shift_data = (r_bitcnt_out != CNT_W'(SIZE));
  assign word_next  = sr;
`else
  assign shift_data = 1'b1;
  assign word_next  = sr_shift;
`endif

  assign consume     = r_valid_out && ready_in;
  assign load        = complete && (!r_valid_out || ready_in);
  assign overrun_set = complete && r_valid_out && !ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sr            <= '0;
      r_bitcnt_out  <= '0;
      r_data_out    <= '0;
      r_valid_out   <= 1'b0;
      r_overrun_out <= 1'b0;
`ifdef SIPO_STREAM_PARITY_EN
      r_parity_err_out <= 1'b0;
`endif
    end else begin
      // Handshake keeps running during a frame abort so a pending word can still drain.
      if (load)         r_valid_out <= 1'b1;
      else if (consume) r_valid_out <= 1'b0;

      if (load) begin
        r_data_out <= word_next;
`ifdef SIPO_STREAM_PARITY_EN
        r_parity_err_out <= (^sr) ^ data_in;
`endif
      end

      if (clr_in) begin
        sr            <= '0;
        r_bitcnt_out  <= '0;
        r_overrun_out <= 1'b0;
      end else if (en_in) begin
        if (shift_data) sr <= sr_shift;
        r_bitcnt_out <= complete ? '0 : r_bitcnt_out + CNT_W'(1);
        if (overrun_set) r_overrun_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_stream.sv
// Directed bench for sipo_stream: an LSB-first and an MSB-first instance share one stimulus stream.
module tb_sipo_stream;
  localparam int SIZE  = 8;
  localparam int CNT_W = $clog2(SIZE + 2);

  logic clk_in = 1'b0;
  logic rst_in, data_in, en_in, clr_in, ready_in;

  logic [SIZE-1:0]  l_data, m_data;
  logic             l_valid, m_valid, l_ovr, m_ovr;
  logic [CNT_W-1:0] l_cnt, m_cnt;
`ifdef SIPO_STREAM_PARITY_EN
  logic l_perr, m_perr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  sipo_stream #(.SIZE(SIZE), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .en_in(en_in),
    .clr_in(clr_in), .ready_in(ready_in), .r_data_out(l_data),
    .r_valid_out(l_valid), .r_overrun_out(l_ovr),
`ifdef SIPO_STREAM_PARITY_EN
    .r_parity_err_out(l_perr),
`endif
    .r_bitcnt_out(l_cnt)
  );

  sipo_stream #(.SIZE(SIZE), .MSB_FIRST(1'b1)) dut_msb (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .en_in(en_in),
    .clr_in(clr_in), .ready_in(ready_in), .r_data_out(m_data),
    .r_valid_out(m_valid), .r_overrun_out(m_ovr),
`ifdef SIPO_STREAM_PARITY_EN
    .r_parity_err_out(m_perr),
`endif
    .r_bitcnt_out(m_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic d, input logic en, input logic clr, input logic rdy, input logic rst);
    data_in  = d;
    en_in    = en;
    clr_in   = clr;
    ready_in = rdy;
    rst_in   = rst;
    @(posedge clk_in);
    #1;
  endtask

  // Sends w LSB-first on the wire; ready is rdy_base except on the frame's final strobe.
  task automatic send_word(input logic [7:0] w, input logic rdy_base, input logic rdy_last);
`ifdef SIPO_STREAM_PARITY_EN
    for (int i = 0; i < 8; i++) step(w[i], 1'b1, 1'b0, rdy_base, 1'b0);
    step(^w, 1'b1, 1'b0, rdy_last, 1'b0);
`else
    for (int i = 0; i < 7; i++) step(w[i], 1'b1, 1'b0, rdy_base, 1'b0);
    step(w[7], 1'b1, 1'b0, rdy_last, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] bits;
    data_in = 0; en_in = 0; clr_in = 0; ready_in = 0; rst_in = 1;
    #1;
    step(0, 0, 0, 0, 1);
    chk("rst_data",  l_data, 0);
    chk("rst_valid", l_valid, 0);
    chk("rst_ovr",   l_ovr, 0);
    chk("rst_cnt",   l_cnt, 0);

    // Bits 1,0,1,1,0,0,1,0 first to last.
    bits = 8'b0100_1101;
    for (int i = 0; i < 7; i++) step(bits[i], 1, 0, 1, 0);
    chk("t1_cnt7",   l_cnt, 7);
    chk("t1_val7",   l_valid, 0);
    step(bits[7], 1, 0, 1, 0);
`ifdef SIPO_STREAM_PARITY_EN
    chk("t1_cnt8_par", l_cnt, 8);
    chk("t1_val8_par", l_valid, 0);
    step(^bits, 1, 0, 1, 0);
`endif
    chk("t1_valid",    l_valid, 1);
    chk("t1_data_lsb", l_data, 8'h4D);
    chk("t1_data_msb", m_data, 8'hB2);
    chk("t1_cnt0",     l_cnt, 0);
    step(0, 0, 0, 1, 0);
    chk("t1_consumed", l_valid, 0);

    // Overrun with the consumer stalled.
    send_word(8'hA5, 0, 0);
    chk("t3_a5_valid", l_valid, 1);
    chk("t3_a5_data",  l_data, 8'hA5);
    chk("t3_a5_ovr",   l_ovr, 0);
    send_word(8'h3C, 0, 0);
    chk("t3_keep_data", l_data, 8'hA5);
    chk("t3_ovr",       l_ovr, 1);
    chk("t3_valid",     l_valid, 1);
    chk("t3_cnt",       l_cnt, 0);
    step(0, 0, 0, 1, 0);
    chk("t3_drain",     l_valid, 0);
    chk("t3_ovr_stick", l_ovr, 1);
    step(0, 0, 1, 0, 0);
    chk("t3_ovr_clr",   l_ovr, 0);

    // Frame abort with a word pending.
    send_word(8'h5A, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    chk("t4_cnt5", l_cnt, 5);
    step(1, 1, 1, 0, 0);
    chk("t4_clr_cnt",   l_cnt, 0);
    chk("t4_clr_valid", l_valid, 1);
    chk("t4_clr_data",  l_data, 8'h5A);
    step(0, 0, 0, 1, 0);
    chk("t4_consume", l_valid, 0);
    send_word(8'h81, 0, 0);
    chk("t4_fresh_lsb", l_data, 8'h81);
    chk("t4_fresh_msb", m_data, 8'h81);
    step(0, 0, 1, 1, 0);
    chk("t4_clr_handshake", l_valid, 0);

    // Completion on the same edge as a consume.
    send_word(8'hF0, 0, 0);
    chk("t5_f0", l_data, 8'hF0);
    send_word(8'h0F, 0, 1);
    chk("t5_valid", l_valid, 1);
    chk("t5_data",  l_data, 8'h0F);
    chk("t5_ovr",   l_ovr, 0);

    // Reset mid-word.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("t6_cnt3", l_cnt, 3);
    step(1, 1, 0, 0, 1);
    chk("t6_data",  l_data, 0);
    chk("t6_valid", l_valid, 0);
    chk("t6_ovr",   l_ovr, 0);
    chk("t6_cnt",   l_cnt, 0);
    chk("t6_mdata", m_data, 0);

`ifdef SIPO_STREAM_PARITY_EN
    bits = 8'h4D;
    for (int i = 0; i < 8; i++) step(bits[i], 1, 0, 1, 0);
    chk("p_val8", l_valid, 0);
    step(0, 1, 0, 1, 0);
    chk("p_good_valid", l_valid, 1);
    chk("p_good_data",  l_data, 8'h4D);
    chk("p_good_err",   l_perr, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(bits[i], 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("p_bad_valid", l_valid, 1);
    chk("p_bad_err",   l_perr, 1);
    chk("p_bad_err_m", m_perr, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
